// File: rtl/jk_ff_bank_if.sv
// Bundles the JK bank control, data and status signals between a driver and the bank.
// No latency of its own; this is wiring only.
// No backpressure: the bank accepts an update on every clock edge.
//
// Signals:
//   en, load, load_val, j, k, cnt_clr  driver -> bank
//   q, q_bar, changed                  bank -> driver (channel state)
//   toggle_cnt, cnt_sat, parity        bank -> driver (status)
interface jk_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             changed;
  logic [CNT_W-1:0] toggle_cnt;
  logic             cnt_sat;
  logic             parity;

  modport master (
    output en, load, load_val, j, k, cnt_clr,
    input  q, q_bar, changed, toggle_cnt, cnt_sat, parity
  );

  modport slave (
    input  en, load, load_val, j, k, cnt_clr,
    output q, q_bar, changed, toggle_cnt, cnt_sat, parity
  );
endinterface

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH independent JK flip-flops, with parallel load, a saturating toggle-event counter and a change pulse.
// q, changed, toggle_cnt, cnt_sat and parity are registered and update one edge after their inputs; q_bar is combinational.
// No backpressure: every rising edge of clk is an update opportunity.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  jk_ff_bank_if.slave (en, load, load_val, j, k, cnt_clr in; q, q_bar, changed, toggle_cnt, cnt_sat, parity out)
// Build option: define JK_FF_BANK_PARITY_EN to register the even parity of q; otherwise parity is tied to 0.
module jk_ff_bank #(
  parameter int WIDTH = 8,   // 1..64
  parameter int CNT_W = 16   // 2..32
) (
  input  logic          clk,
  input  logic          rst,
  jk_ff_bank_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             tog_evt;

  // Next channel state: load has priority over en; en low holds.
  // JK characteristic per bit: q+ = (j & ~q) | (~k & q).
  always_comb begin
    q_d     = q_q;
    tog_evt = 1'b0;
    if (bus.load) begin
      q_d = bus.load_val;
    end else if (bus.en) begin
      q_d     = (bus.j & ~q_q) | (~bus.k & q_q);
      tog_evt = |(bus.j & bus.k);
    end
  end

  assign changed_d = (q_d != q_q);

  // One count per edge with any toggling bit. Clear beats a coincident toggle.
  // The sticky flag rises on the same edge the counter first reaches all-ones.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (tog_evt) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q       <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

`ifdef JK_FF_BANK_PARITY_EN
  // Parity is taken from the next state so it lines up with the q it describes.
  logic parity_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign bus.parity = parity_q;
`else
  assign bus.parity = 1'b0;
`endif

  assign bus.q          = q_q;
  assign bus.q_bar      = ~q_q;
  assign bus.changed    = changed_q;
  assign bus.toggle_cnt = cnt_q;
  assign bus.cnt_sat    = sat_q;

endmodule

// File: doc/jk_ff_bank.md
JK_FF_BANK -- requirements
Module: jk_ff_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent JK channels; legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the toggle-event counter; legal range 2..32.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, asynchronous assert, active-low.
REQ-005 Port en  input  1: channel update enable; when low, q holds.
REQ-006 Port load  input  1: parallel load strobe.
REQ-007 Port load_val  input  WIDTH: value written to q on load.
REQ-008 Port j  input  WIDTH: per-channel J input.
REQ-009 Port k  input  WIDTH: per-channel K input.
REQ-010 Port cnt_clr  input  1: synchronous clear of toggle_cnt and cnt_sat.
REQ-011 Port q  output  WIDTH: registered channel state.
REQ-012 Port q_bar  output  WIDTH: combinational bitwise inverse of q.
REQ-013 Port changed  output  1: registered one-cycle pulse, high in the cycle after any q bit changed value.
REQ-014 Port toggle_cnt  output  CNT_W: count of edges on which at least one channel executed a toggle (J=K=1).
REQ-015 Port cnt_sat  output  1: sticky flag, high once toggle_cnt has reached all-ones.
REQ-016 Port parity  output  1: registered even parity of q (see Configuration).

Function
REQ-017 Priority per edge: load > en > hold.
REQ-018 load=1: q <= load_val regardless of en, j, k; no toggle event is counted on that edge.
REQ-019 load=0, en=1: each bit i updates by {j[i],k[i]}: 00 hold, 01 clear, 10 set, 11 invert.
REQ-020 load=0, en=0: q holds; j/k ignored; no toggle event is counted.
REQ-021 Toggle event: load=0, en=1, and (j & k) nonzero; exactly one count per edge regardless of how many bits toggle.
REQ-022 toggle_cnt increments by 1 per toggle event; at all-ones it saturates (no wrap) and cnt_sat is set on that same edge.
REQ-023 cnt_sat remains high until cnt_clr or reset.
REQ-024 cnt_clr=1 with a simultaneous toggle event: clear wins; toggle_cnt=0, cnt_sat=0 after the edge.
REQ-025 cnt_clr does not affect q, changed, or parity.
REQ-026 changed: set on an edge where next q != current q, otherwise cleared; latency one cycle from the q update edge, i.e. high in the same cycle q shows its new value.
REQ-027 A load of a value equal to current q does not raise changed.
REQ-028 q_bar tracks q with zero latency; no register.

Reset
REQ-029 rst low immediately forces q=0, changed=0, toggle_cnt=0, cnt_sat=0, parity=0, independent of clk.
REQ-030 q_bar reads all-ones while in reset.
REQ-031 Reset asserted mid-operation discards any pending load/toggle; first update occurs on the first rising clk edge with rst high.
REQ-032 Deassertion has no required synchronisation inside the block; it is the integrator's responsibility.

Configuration
REQ-033 Macro JK_FF_BANK_PARITY_EN defined: parity register updates every edge to XOR-reduction of next q (registered, same cycle as q).
REQ-034 Macro JK_FF_BANK_PARITY_EN undefined: parity port remains present and is tied to constant 0; no parity logic is synthesised.

Verification
REQ-035 WIDTH=8: rst low for 2 cycles while j=k=FF, en=1 -> q=00, q_bar=FF, toggle_cnt=0 throughout; rst asynchronously low mid-cycle -> q=00 before next edge.
REQ-036 After reset, en=1, j=F0, k=0F for 1 edge, then j=k=FF for 3 edges -> q=F0, 0F, F0, 0F; toggle_cnt=3; changed high each cycle after each update.
REQ-037 q=0F, load=1, load_val=0F, en=1, j=k=FF -> q stays 0F, changed=0, toggle_cnt unchanged.
REQ-038 CNT_W=2: 3 toggle edges -> toggle_cnt=3, cnt_sat=1; 2 more toggle edges -> toggle_cnt stays 3, cnt_sat stays 1; cnt_clr=1 alongside a toggle edge -> toggle_cnt=0, cnt_sat=0.
REQ-039 en=0, j=k=FF for 4 edges -> q, toggle_cnt unchanged; changed=0.
REQ-040 Macro defined, load_val=07 -> parity=1 with q=07; load_val=03 -> parity=0; macro undefined -> parity=0 for all q.
